// File: rtl/hardwired_control_unit.sv
// Hardwired sequencer for ALU_System: INIT, two-byte fetch, single-cycle execute, HLT hold.
// Optional retired-instruction counter enabled by defining CU_INSTR_COUNT_EN.
module hardwired_control_unit #(
  parameter bit CLEAR_RF_ON_INIT = 1'b1,
  parameter int INSTR_CNT_W      = 16
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic [15:0]            IROut,
  input  logic [3:0]             ALUOutFlag,
  output logic [2:0]             RF_OutASel,
  output logic [2:0]             RF_OutBSel,
  output logic [1:0]             RF_FunSel,
  output logic [3:0]             RF_RSel,
  output logic [3:0]             RF_TSel,
  output logic [3:0]             ALU_FunSel,
  output logic [1:0]             ARF_OutCSel,
  output logic [1:0]             ARF_OutDSel,
  output logic [1:0]             ARF_FunSel,
  output logic [3:0]             ARF_RegSel,
  output logic                   IR_LH,
  output logic                   IR_Enable,
  output logic [1:0]             IR_Funsel,
  output logic                   Mem_WR,
  output logic                   Mem_CS,
  output logic [1:0]             MuxASel,
  output logic [1:0]             MuxBSel,
  output logic                   MuxCSel,
  output logic [1:0]             SeqState,
  output logic [INSTR_CNT_W-1:0] InstrCount
);

  typedef enum logic [1:0] {
    INIT    = 2'b00,
    FETCH_L = 2'b01,
    FETCH_H = 2'b10,
    EXEC    = 2'b11
  } state_t;

  localparam logic [1:0] FN_CLR = 2'b00;
  localparam logic [1:0] FN_LD  = 2'b01;
  localparam logic [1:0] FN_DEC = 2'b10;
  localparam logic [1:0] FN_INC = 2'b11;

  state_t     state, state_nxt;
  logic       halted, halted_nxt;
  logic [3:0] op;
  logic [1:0] rd, rs;
  logic [3:0] rd_en;
  logic       unused_ir;

  assign op       = IROut[15:12];
  assign rd       = IROut[11:10];
  assign rs       = IROut[9:8];
  assign rd_en    = 4'b1000 >> rd;
  assign SeqState = state;
  // Immediate/address byte is consumed by ALU_System directly, Z is the only flag we branch on.
  assign unused_ir = ^{IROut[7:0], ALUOutFlag[2:0]};

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state  <= INIT;
      halted <= 1'b0;
    end else begin
      state  <= state_nxt;
      halted <= halted_nxt;
    end
  end

  always_comb begin
    RF_OutASel  = 3'b000;
    RF_OutBSel  = 3'b000;
    RF_FunSel   = FN_CLR;
    RF_RSel     = 4'b0000;
    RF_TSel     = 4'b0000;
    ALU_FunSel  = 4'b0000;
    ARF_OutCSel = 2'b00;
    ARF_OutDSel = 2'b00;
    ARF_FunSel  = FN_CLR;
    ARF_RegSel  = 4'b0000;
    IR_LH       = 1'b0;
    IR_Enable   = 1'b0;
    IR_Funsel   = FN_CLR;
    Mem_WR      = 1'b0;
    Mem_CS      = 1'b1;
    MuxASel     = 2'b00;
    MuxBSel     = 2'b00;
    MuxCSel     = 1'b0;
    state_nxt   = state;
    halted_nxt  = halted;

    case (state)
      INIT: begin
        ARF_RegSel = 4'b1000;
        ARF_FunSel = FN_CLR;
        if (CLEAR_RF_ON_INIT) begin
          RF_RSel   = 4'b1111;
          RF_FunSel = FN_CLR;
        end
        state_nxt = FETCH_L;
      end

      // Both fetch cycles read mem[PC] into one IR byte and post-increment PC.
      FETCH_L, FETCH_H: begin
        ARF_OutDSel = 2'b00;
        Mem_CS      = 1'b0;
        IR_Enable   = 1'b1;
        IR_LH       = (state == FETCH_H);
        IR_Funsel   = FN_LD;
        ARF_RegSel  = 4'b1000;
        ARF_FunSel  = FN_INC;
        state_nxt   = (state == FETCH_L) ? FETCH_H : EXEC;
      end

      EXEC: begin
        if (!halted) begin
          state_nxt = FETCH_L;
          case (op)
            4'h0: begin
              MuxASel   = 2'b10;
              RF_RSel   = rd_en;
              RF_FunSel = FN_LD;
            end
            4'h1: begin
              ARF_OutDSel = 2'b01;
              Mem_CS      = 1'b0;
              MuxASel     = 2'b01;
              RF_RSel     = rd_en;
              RF_FunSel   = FN_LD;
            end
            4'h2: begin
              RF_OutASel  = {1'b0, rd};
              MuxCSel     = 1'b1;
              ALU_FunSel  = 4'b0000;
              ARF_OutDSel = 2'b01;
              Mem_CS      = 1'b0;
              Mem_WR      = 1'b1;
            end
            4'h3: begin
              MuxBSel    = 2'b10;
              ARF_RegSel = 4'b0100;
              ARF_FunSel = FN_LD;
            end
            4'h4, 4'h5, 4'h6, 4'h7, 4'h8: begin
              RF_OutASel = {1'b0, rd};
              RF_OutBSel = {1'b0, rs};
              MuxCSel    = 1'b1;
              MuxASel    = 2'b00;
              RF_RSel    = rd_en;
              RF_FunSel  = FN_LD;
              case (op)
                4'h4:    ALU_FunSel = 4'b0100;
                4'h5:    ALU_FunSel = 4'b0110;
                4'h6:    ALU_FunSel = 4'b0111;
                4'h7:    ALU_FunSel = 4'b1000;
                default: ALU_FunSel = 4'b1001;
              endcase
            end
            4'h9: begin
              RF_OutASel = {1'b0, rs};
              MuxCSel    = 1'b1;
              ALU_FunSel = 4'b0010;
              MuxASel    = 2'b00;
              RF_RSel    = rd_en;
              RF_FunSel  = FN_LD;
            end
            4'hA: begin
              RF_RSel   = rd_en;
              RF_FunSel = FN_INC;
            end
            4'hB: begin
              RF_RSel   = rd_en;
              RF_FunSel = FN_DEC;
            end
            4'hC, 4'hD, 4'hE: begin
              // BRA always, BEQ on Z=1, BNE on Z=0; a not-taken branch is a pure no-op.
              if (op == 4'hC || (op == 4'hD && ALUOutFlag[3]) || (op == 4'hE && !ALUOutFlag[3])) begin
                MuxBSel    = 2'b10;
                ARF_RegSel = 4'b1000;
                ARF_FunSel = FN_LD;
              end
            end
            default: begin
              halted_nxt = 1'b1;
              state_nxt  = EXEC;
            end
          endcase
        end
      end

      default: state_nxt = INIT;
    endcase
  end

`ifdef CU_INSTR_COUNT_EN
  logic [INSTR_CNT_W-1:0] instr_cnt;

  // The HLT execute cycle itself retires; only the hold cycles after it are frozen.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset)
      instr_cnt <= '0;
    else if (state == EXEC && !halted)
      instr_cnt <= instr_cnt + {{(INSTR_CNT_W-1){1'b0}}, 1'b1};
  end

  assign InstrCount = instr_cnt;
`else
  assign InstrCount = '0;
`endif

endmodule

// File: tb/tb_hardwired_control_unit.sv
// Scoreboard bench for hardwired_control_unit: expected control words are queued per cycle
// and popped at the falling edge; a small PC/IR/memory model closes the fetch loop.
module tb_hardwired_control_unit;

  typedef struct packed {
    logic [1:0] seq;
    logic [2:0] oa, ob;
    logic [1:0] rf_fun;
    logic [3:0] rsel, tsel, alu;
    logic [1:0] oc, od, arf_fun;
    logic [3:0] regsel;
    logic       ir_lh, ir_en;
    logic [1:0] ir_fun;
    logic       wr, cs;
    logic [1:0] ma, mb;
    logic       mc;
  } ctl_t;

  typedef struct {
    string name;
    ctl_t  v;
  } exp_t;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [15:0] IROut;
  logic [3:0]  ALUOutFlag;
  logic [2:0]  RF_OutASel, RF_OutBSel;
  logic [1:0]  RF_FunSel;
  logic [3:0]  RF_RSel, RF_TSel, ALU_FunSel;
  logic [1:0]  ARF_OutCSel, ARF_OutDSel, ARF_FunSel;
  logic [3:0]  ARF_RegSel;
  logic        IR_LH, IR_Enable;
  logic [1:0]  IR_Funsel;
  logic        Mem_WR, Mem_CS;
  logic [1:0]  MuxASel, MuxBSel;
  logic        MuxCSel;
  logic [1:0]  SeqState;
  logic [15:0] InstrCount;

  int          checks = 0;
  int          failures = 0;
  exp_t        sb[$];
  logic        use_model;
  logic [15:0] ir_force;
  logic [15:0] exp_cnt;
  logic [15:0] exp_ic;

  logic [7:0]  mem [0:255];
  logic [7:0]  pc;
  logic [15:0] ir_m;
  ctl_t        smp;

  hardwired_control_unit dut (
    .Clock(Clock), .Reset(Reset), .IROut(IROut), .ALUOutFlag(ALUOutFlag),
    .RF_OutASel(RF_OutASel), .RF_OutBSel(RF_OutBSel), .RF_FunSel(RF_FunSel),
    .RF_RSel(RF_RSel), .RF_TSel(RF_TSel), .ALU_FunSel(ALU_FunSel),
    .ARF_OutCSel(ARF_OutCSel), .ARF_OutDSel(ARF_OutDSel), .ARF_FunSel(ARF_FunSel),
    .ARF_RegSel(ARF_RegSel), .IR_LH(IR_LH), .IR_Enable(IR_Enable), .IR_Funsel(IR_Funsel),
    .Mem_WR(Mem_WR), .Mem_CS(Mem_CS), .MuxASel(MuxASel), .MuxBSel(MuxBSel),
    .MuxCSel(MuxCSel), .SeqState(SeqState), .InstrCount(InstrCount)
  );

  always #5 Clock = ~Clock;

  assign IROut = use_model ? ir_m : ir_force;

  function automatic ctl_t obs();
    ctl_t c;
    c.seq = SeqState; c.oa = RF_OutASel; c.ob = RF_OutBSel; c.rf_fun = RF_FunSel;
    c.rsel = RF_RSel; c.tsel = RF_TSel; c.alu = ALU_FunSel; c.oc = ARF_OutCSel;
    c.od = ARF_OutDSel; c.arf_fun = ARF_FunSel; c.regsel = ARF_RegSel; c.ir_lh = IR_LH;
    c.ir_en = IR_Enable; c.ir_fun = IR_Funsel; c.wr = Mem_WR; c.cs = Mem_CS;
    c.ma = MuxASel; c.mb = MuxBSel; c.mc = MuxCSel;
    return c;
  endfunction

  // Minimal ALU_System stand-in: PC under ARF control, IR loaded byte-wise from mem[PC].
  always @(negedge Clock) smp = obs();
  always @(posedge Clock) begin
    logic [7:0] rdata;
    rdata = mem[pc];
    if (smp.ir_en && !smp.cs && smp.ir_fun == 2'b01 && smp.od == 2'b00) begin
      if (smp.ir_lh) ir_m[15:8] = rdata;
      else           ir_m[7:0]  = rdata;
    end
    if (smp.regsel[3]) begin
      case (smp.arf_fun)
        2'b00:   pc = 8'h00;
        2'b01:   pc = ir_m[7:0];
        2'b10:   pc = pc - 8'h01;
        default: pc = pc + 8'h01;
      endcase
    end
  end

  function automatic ctl_t m_idle(input logic [1:0] s);
    ctl_t c = '0;
    c.seq = s; c.cs = 1'b1;
    return c;
  endfunction

  function automatic ctl_t m_init();
    ctl_t c = m_idle(2'b00);
    c.regsel = 4'b1000; c.arf_fun = 2'b00; c.rsel = 4'b1111; c.rf_fun = 2'b00;
    return c;
  endfunction

  function automatic ctl_t m_fetch(input logic hi);
    ctl_t c = m_idle(hi ? 2'b10 : 2'b01);
    c.cs = 1'b0; c.ir_en = 1'b1; c.ir_lh = hi; c.ir_fun = 2'b01;
    c.regsel = 4'b1000; c.arf_fun = 2'b11; c.od = 2'b00;
    return c;
  endfunction

  function automatic ctl_t m_exec(input logic [15:0] ir, input logic [3:0] fl);
    ctl_t c = m_idle(2'b11);
    logic [3:0] en = 4'b1000 >> ir[11:10];
    case (ir[15:12])
      4'h0: begin c.ma = 2'b10; c.rsel = en; c.rf_fun = 2'b01; end
      4'h1: begin c.od = 2'b01; c.cs = 1'b0; c.ma = 2'b01; c.rsel = en; c.rf_fun = 2'b01; end
      4'h2: begin c.oa = {1'b0, ir[11:10]}; c.mc = 1'b1; c.od = 2'b01; c.cs = 1'b0; c.wr = 1'b1; end
      4'h3: begin c.mb = 2'b10; c.regsel = 4'b0100; c.arf_fun = 2'b01; end
      4'h4, 4'h5, 4'h6, 4'h7, 4'h8: begin
        c.oa = {1'b0, ir[11:10]}; c.ob = {1'b0, ir[9:8]}; c.mc = 1'b1;
        c.rsel = en; c.rf_fun = 2'b01;
        c.alu = (ir[15:12] == 4'h4) ? 4'b0100 : (ir[15:12] == 4'h5) ? 4'b0110 :
                (ir[15:12] == 4'h6) ? 4'b0111 : (ir[15:12] == 4'h7) ? 4'b1000 : 4'b1001;
      end
      4'h9: begin c.oa = {1'b0, ir[9:8]}; c.mc = 1'b1; c.alu = 4'b0010; c.rsel = en; c.rf_fun = 2'b01; end
      4'hA: begin c.rsel = en; c.rf_fun = 2'b11; end
      4'hB: begin c.rsel = en; c.rf_fun = 2'b10; end
      4'hC: begin c.mb = 2'b10; c.regsel = 4'b1000; c.arf_fun = 2'b01; end
      4'hD: if (fl[3])  begin c.mb = 2'b10; c.regsel = 4'b1000; c.arf_fun = 2'b01; end
      4'hE: if (!fl[3]) begin c.mb = 2'b10; c.regsel = 4'b1000; c.arf_fun = 2'b01; end
      default: ;
    endcase
    return c;
  endfunction

  task automatic test_reset();
    exp_t e; ctl_t o;
    Reset = 1'b1;
    @(negedge Clock); @(negedge Clock);
    sb.push_back('{"reset_init", m_init()});
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = obs(); checks++;
      if (o !== e.v) begin failures++; $display("FAIL %s: got %h exp %h", e.name, o, e.v); end
      if (sb.size() > 0) @(negedge Clock);
    end
    checks++;
    if (InstrCount !== 16'd0) begin failures++; $display("FAIL reset_count: got %0d exp 0", InstrCount); end
    Reset = 1'b0;
    @(negedge Clock);
    sb.push_back('{"first_fetch_l", m_fetch(1'b0)});
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = obs(); checks++;
      if (o !== e.v) begin failures++; $display("FAIL %s: got %h exp %h", e.name, o, e.v); end
      if (sb.size() > 0) @(negedge Clock);
    end
    checks++;
    if (pc !== 8'h00) begin failures++; $display("FAIL init_pc_clear: got %h exp 00", pc); end
  endtask

  task automatic test_fetch_ldi();
    exp_t e; ctl_t o; ctl_t x;
    x = m_idle(2'b11); x.ma = 2'b10; x.rsel = 4'b1000; x.rf_fun = 2'b01;
    sb.push_back('{"ldi_fetch_l", m_fetch(1'b0)});
    sb.push_back('{"ldi_fetch_h", m_fetch(1'b1)});
    sb.push_back('{"ldi_exec", x});
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = obs(); checks++;
      if (o !== e.v) begin failures++; $display("FAIL %s: got %h exp %h", e.name, o, e.v); end
      if (sb.size() > 0) @(negedge Clock);
    end
    @(negedge Clock);
    exp_cnt = exp_cnt + 16'd1;
    checks++;
    if (pc !== 8'h02 || SeqState !== 2'b01) begin
      failures++; $display("FAIL ldi_pc_after: got pc=%h seq=%b exp pc=02 seq=01", pc, SeqState);
    end
`ifdef CU_INSTR_COUNT_EN
    exp_ic = exp_cnt;
`else
    exp_ic = 16'd0;
`endif
    checks++;
    if (InstrCount !== exp_ic) begin failures++; $display("FAIL ldi_count: got %0d exp %0d", InstrCount, exp_ic); end
    use_model = 1'b0;
  endtask

  task automatic test_add();
    exp_t e; ctl_t o; ctl_t x;
    x = m_idle(2'b11);
    x.oa = 3'b000; x.ob = 3'b001; x.alu = 4'b0100; x.mc = 1'b1; x.ma = 2'b00;
    x.rsel = 4'b1000; x.rf_fun = 2'b01;
    ir_force = 16'h4100; ALUOutFlag = 4'b0000; #1;
    sb.push_back('{"add_fetch_l", m_fetch(1'b0)});
    sb.push_back('{"add_fetch_h", m_fetch(1'b1)});
    sb.push_back('{"add_exec", x});
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = obs(); checks++;
      if (o !== e.v) begin failures++; $display("FAIL %s: got %h exp %h", e.name, o, e.v); end
      if (sb.size() > 0) @(negedge Clock);
    end
    @(negedge Clock);
    exp_cnt = exp_cnt + 16'd1;
  endtask

  task automatic test_back_to_back();
    exp_t e; ctl_t o;
    logic [15:0] tbl [14];
    tbl = '{16'h5E00, 16'h6500, 16'h7A00, 16'h8700, 16'h9B00, 16'hA400, 16'hBC00,
            16'h1833, 16'h2C40, 16'h3012, 16'h0E7F, 16'hC020, 16'h4D00, 16'h9000};
    for (int i = 0; i < 14; i++) begin
      ir_force = tbl[i]; ALUOutFlag = 4'($urandom); #1;
      sb.push_back('{$sformatf("op_%h_fetch_l", tbl[i]), m_fetch(1'b0)});
      sb.push_back('{$sformatf("op_%h_fetch_h", tbl[i]), m_fetch(1'b1)});
      sb.push_back('{$sformatf("op_%h_exec", tbl[i]), m_exec(tbl[i], ALUOutFlag)});
      while (sb.size() > 0) begin
        e = sb.pop_front(); o = obs(); checks++;
        if (o !== e.v) begin failures++; $display("FAIL %s: got %h exp %h", e.name, o, e.v); end
        if (sb.size() > 0) @(negedge Clock);
      end
      @(negedge Clock);
      exp_cnt = exp_cnt + 16'd1;
`ifdef CU_INSTR_COUNT_EN
      exp_ic = exp_cnt;
`else
      exp_ic = 16'd0;
`endif
      checks++;
      if (InstrCount !== exp_ic) begin
        failures++; $display("FAIL count_after_%h: got %0d exp %0d", tbl[i], InstrCount, exp_ic);
      end
    end
  endtask

  task automatic test_branch();
    exp_t e; ctl_t o; ctl_t x;
    logic [15:0] ir_t [4];
    logic        z_t  [4];
    logic        tk_t [4];
    ir_t = '{16'hD020, 16'hD020, 16'hE020, 16'hE020};
    z_t  = '{1'b1, 1'b0, 1'b0, 1'b1};
    tk_t = '{1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      ir_force = ir_t[i]; ALUOutFlag = {z_t[i], 3'($urandom)}; #1;
      x = m_idle(2'b11);
      if (tk_t[i]) begin x.regsel = 4'b1000; x.arf_fun = 2'b01; x.mb = 2'b10; end
      sb.push_back('{$sformatf("br_%h_z%0d_fetch_l", ir_t[i], z_t[i]), m_fetch(1'b0)});
      sb.push_back('{$sformatf("br_%h_z%0d_fetch_h", ir_t[i], z_t[i]), m_fetch(1'b1)});
      sb.push_back('{$sformatf("br_%h_z%0d_exec", ir_t[i], z_t[i]), x});
      while (sb.size() > 0) begin
        e = sb.pop_front(); o = obs(); checks++;
        if (o !== e.v) begin failures++; $display("FAIL %s: got %h exp %h", e.name, o, e.v); end
        if (sb.size() > 0) @(negedge Clock);
      end
      @(negedge Clock);
      exp_cnt = exp_cnt + 16'd1;
    end
  endtask

  task automatic test_reset_mid();
    exp_t e; ctl_t o;
    ir_force = 16'h4100; #1;
    @(negedge Clock);
    sb.push_back('{"mid_fetch_h", m_fetch(1'b1)});
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = obs(); checks++;
      if (o !== e.v) begin failures++; $display("FAIL %s: got %h exp %h", e.name, o, e.v); end
      if (sb.size() > 0) @(negedge Clock);
    end
    #2 Reset = 1'b1; #1;
    sb.push_back('{"async_reset_in_fetch_h", m_init()});
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = obs(); checks++;
      if (o !== e.v) begin failures++; $display("FAIL %s: got %h exp %h", e.name, o, e.v); end
      if (sb.size() > 0) @(negedge Clock);
    end
    checks++;
    if (InstrCount !== 16'd0) begin failures++; $display("FAIL mid_reset_count: got %0d exp 0", InstrCount); end
    exp_cnt = 16'd0;
    @(negedge Clock); Reset = 1'b0;
    @(negedge Clock);
    ir_force = 16'h2C40; #1;
    @(negedge Clock); @(negedge Clock);
    sb.push_back('{"st_exec_before_reset", m_exec(16'h2C40, ALUOutFlag)});
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = obs(); checks++;
      if (o !== e.v) begin failures++; $display("FAIL %s: got %h exp %h", e.name, o, e.v); end
      if (sb.size() > 0) @(negedge Clock);
    end
    #2 Reset = 1'b1; #1;
    sb.push_back('{"async_reset_in_st_exec", m_init()});
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = obs(); checks++;
      if (o !== e.v) begin failures++; $display("FAIL %s: got %h exp %h", e.name, o, e.v); end
      if (sb.size() > 0) @(negedge Clock);
    end
    @(negedge Clock); Reset = 1'b0;
    @(negedge Clock);
  endtask

  task automatic test_halt();
    exp_t e; ctl_t o;
    ir_force = 16'hF000; #1;
    sb.push_back('{"hlt_fetch_l", m_fetch(1'b0)});
    sb.push_back('{"hlt_fetch_h", m_fetch(1'b1)});
    sb.push_back('{"hlt_exec", m_idle(2'b11)});
    for (int i = 0; i < 10; i++) sb.push_back('{$sformatf("hlt_hold_%0d", i), m_idle(2'b11)});
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = obs(); checks++;
      if (o !== e.v) begin failures++; $display("FAIL %s: got %h exp %h", e.name, o, e.v); end
      if (sb.size() > 0) @(negedge Clock);
    end
    exp_cnt = exp_cnt + 16'd1;
`ifdef CU_INSTR_COUNT_EN
    exp_ic = exp_cnt;
`else
    exp_ic = 16'd0;
`endif
    checks++;
    if (InstrCount !== exp_ic) begin failures++; $display("FAIL hlt_count_frozen: got %0d exp %0d", InstrCount, exp_ic); end
    #2 Reset = 1'b1; #1;
    sb.push_back('{"hlt_reset_init", m_init()});
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = obs(); checks++;
      if (o !== e.v) begin failures++; $display("FAIL %s: got %h exp %h", e.name, o, e.v); end
      if (sb.size() > 0) @(negedge Clock);
    end
    @(negedge Clock); Reset = 1'b0;
    @(negedge Clock);
    sb.push_back('{"post_halt_fetch_l", m_fetch(1'b0)});
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = obs(); checks++;
      if (o !== e.v) begin failures++; $display("FAIL %s: got %h exp %h", e.name, o, e.v); end
      if (sb.size() > 0) @(negedge Clock);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b1; ALUOutFlag = 4'b0000; ir_force = 16'h0000; use_model = 1'b1;
    exp_cnt = 16'd0; pc = 8'h00; ir_m = 16'h0000;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[0] = 8'h05;
    mem[1] = 8'h00;
    test_reset();
    test_fetch_ldi();
    test_add();
    test_back_to_back();
    test_branch();
    test_reset_mid();
    test_halt();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
